// File: rtl/divider_iter_pkg.sv
// Shared definitions for the iterative divider: default width, counter width and FSM states.
package divider_iter_pkg;

    localparam int DIV_WIDTH = 32;
    localparam int DIV_CNT_W = $clog2(DIV_WIDTH) + 1;

    typedef enum logic [1:0] {
        DIV_IDLE,
        DIV_BUSY,
        DIV_DONE
    } div_state_t;

endpackage

// File: rtl/divider_iter_if.sv
// Request/response bundle between the execute stage (master) and the divider (slave).
import divider_iter_pkg::*;

interface divider_iter_if #(parameter int WIDTH = DIV_WIDTH);

    logic             in_valid;
    logic             sign;
    logic [WIDTH-1:0] srca;
    logic [WIDTH-1:0] srcb;
    logic             out_valid;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (
        output in_valid, sign, srca, srcb,
        input  out_valid, hi, lo
    );

    modport slave (
        input  in_valid, sign, srca, srcb,
        output out_valid, hi, lo
    );

endinterface

// File: rtl/divider_iter_div_step.sv
// One restoring division iteration: shift {rem, quo} left, trial-subtract, restore on borrow.
import divider_iter_pkg::*;

module div_step #(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic [WIDTH-1:0] rem,
    input  logic [WIDTH-1:0] quo,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] rem_next,
    output logic [WIDTH-1:0] quo_next
);

    logic [WIDTH:0]   shifted;
    logic             fits;
    logic [WIDTH-1:0] trial;

    // When the subtraction fits, its result is below the divisor, so WIDTH bits hold it.
    always_comb begin
        shifted  = {rem, quo[WIDTH-1]};
        fits     = shifted >= {1'b0, divisor};
        trial    = shifted[WIDTH-1:0] - divisor;
        rem_next = fits ? trial : shifted[WIDTH-1:0];
        quo_next = {quo[WIDTH-2:0], fits};
    end

endmodule

// File: rtl/divider_iter.sv
// Multi-cycle radix-2 restoring divider: signed/unsigned quotient on lo, remainder on hi.
import divider_iter_pkg::*;

module divider_iter #(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic           clk,
    input  logic           rst,
    divider_iter_if.slave  bus
);

    localparam logic [DIV_CNT_W-1:0] LAST_STEP = DIV_CNT_W'(WIDTH - 1);

    div_state_t           state_q, state_d;
    logic [DIV_CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0]     rem_q, rem_d;
    logic [WIDTH-1:0]     quo_q, quo_d;
    logic [WIDTH-1:0]     dvs_q, dvs_d;
    logic                 neg_a_q, neg_a_d;
    logic                 neg_b_q, neg_b_d;
    logic [WIDTH-1:0]     hi_q, hi_d;
    logic [WIDTH-1:0]     lo_q, lo_d;

    logic [WIDTH-1:0]     rem_step;
    logic [WIDTH-1:0]     quo_step;

    div_step #(.WIDTH(WIDTH)) u_step (
        .rem      (rem_q),
        .quo      (quo_q),
        .divisor  (dvs_q),
        .rem_next (rem_step),
        .quo_next (quo_step)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rem_d   = rem_q;
        quo_d   = quo_q;
        dvs_d   = dvs_q;
        neg_a_d = neg_a_q;
        neg_b_d = neg_b_q;
        hi_d    = hi_q;
        lo_d    = lo_q;

        case (state_q)
            DIV_IDLE: begin
                if (bus.in_valid) begin
                    // Sign flags are only set for DIV, so DIVU operands pass through unchanged.
                    neg_a_d = bus.sign & bus.srca[WIDTH-1];
                    neg_b_d = bus.sign & bus.srcb[WIDTH-1];
                    quo_d   = neg_a_d ? -bus.srca : bus.srca;
                    dvs_d   = neg_b_d ? -bus.srcb : bus.srcb;
                    rem_d   = '0;
                    cnt_d   = '0;
                    state_d = DIV_BUSY;
                end
            end
            DIV_BUSY: begin
                rem_d = rem_step;
                quo_d = quo_step;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == LAST_STEP) begin
                    state_d = DIV_DONE;
                    // A zero divisor keeps the all-ones quotient; the remainder fix restores srca.
                    lo_d = ((neg_a_q ^ neg_b_q) && (dvs_q != '0)) ? -quo_step : quo_step;
                    hi_d = neg_a_q ? -rem_step : rem_step;
                end
            end
            DIV_DONE: begin
                state_d = DIV_IDLE;
            end
            default: begin
                state_d = DIV_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= DIV_IDLE;
            cnt_q   <= '0;
            rem_q   <= '0;
            quo_q   <= '0;
            dvs_q   <= '0;
            neg_a_q <= 1'b0;
            neg_b_q <= 1'b0;
            hi_q    <= '0;
            lo_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rem_q   <= rem_d;
            quo_q   <= quo_d;
            dvs_q   <= dvs_d;
            neg_a_q <= neg_a_d;
            neg_b_q <= neg_b_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
        end
    end

    assign bus.out_valid = (state_q == DIV_DONE);
    assign bus.hi        = hi_q;
    assign bus.lo        = lo_q;

endmodule

// File: tb/tb_divider_iter.sv
// Scoreboard bench for divider_iter: directed vectors push expectations, a monitor checks each out_valid pulse.
module tb_divider_iter;

    logic clk;
    logic rst;
    int   cyc;
    int   checks;
    int   errors;

    divider_iter_if #(.WIDTH(32)) bus ();

    divider_iter #(.WIDTH(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        string       tag;
        logic [31:0] hi;
        logic [31:0] lo;
        int          cyc;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks = checks + 1;
        if (actual !== expected) begin
            errors = errors + 1;
            $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
        end
    endtask

    // Every out_valid pulse must match the oldest outstanding expectation, including its cycle.
    always @(negedge clk) begin
        if (!rst && bus.out_valid === 1'b1) begin
            if (sb.size() == 0) begin
                checkOutput("spurious_out_valid", 32'd1, 32'd0);
            end else begin
                mon_e = sb.pop_front();
                checkOutput({mon_e.tag, ".hi"}, bus.hi, mon_e.hi);
                checkOutput({mon_e.tag, ".lo"}, bus.lo, mon_e.lo);
                checkOutput({mon_e.tag, ".cycle"}, 32'(cyc), 32'(mon_e.cyc));
            end
        end
    end

    // Issues a request and waits for its pulse; extra is the number of cycles before the DUT can capture.
    task automatic applyStimulus(input string tag, input logic s, input logic [31:0] a, input logic [31:0] b,
                                 input logic [31:0] exp_hi, input logic [31:0] exp_lo,
                                 input bit keep, input bit scramble, input int extra);
        exp_t e;
        bit   seen;
        bus.in_valid = 1'b1;
        bus.sign     = s;
        bus.srca     = a;
        bus.srcb     = b;
        e.tag = tag;
        e.hi  = exp_hi;
        e.lo  = exp_lo;
        e.cyc = cyc + extra + 33;
        sb.push_back(e);
        seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge clk);
            if (bus.out_valid === 1'b1) begin
                seen = 1'b1;
            end else if (scramble && i > extra) begin
                bus.sign = $urandom_range(0, 1) == 1;
                bus.srca = $urandom;
                bus.srcb = $urandom;
            end
        end
        if (!seen) begin
            checkOutput({tag, ".timeout"}, 32'd0, 32'd1);
            if (sb.size() != 0) void'(sb.pop_back());
        end
        if (!keep) bus.in_valid = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        cyc          = 0;
        checks       = 0;
        errors       = 0;
        rst          = 1'b1;
        bus.in_valid = 1'b0;
        bus.sign     = 1'b0;
        bus.srca     = '0;
        bus.srcb     = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        @(negedge clk);
        checkOutput("reset.out_valid", {31'd0, bus.out_valid}, 32'd0);
        checkOutput("reset.hi", bus.hi, 32'd0);
        checkOutput("reset.lo", bus.lo, 32'd0);

        @(posedge clk); #1;
        applyStimulus("udiv_100_7", 1'b0, 32'd100, 32'd7, 32'd2, 32'd14, 1'b0, 1'b0, 0);
        repeat (40) @(negedge clk);

        @(posedge clk); #1;
        applyStimulus("sdiv_m7_2", 1'b1, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0, 1'b0, 0);
        @(posedge clk); #1;
        applyStimulus("sdiv_7_m2", 1'b1, 32'd7, 32'hFFFFFFFE, 32'd1, 32'hFFFFFFFD, 1'b0, 1'b0, 0);
        @(posedge clk); #1;
        applyStimulus("sdiv_m100_m7", 1'b1, 32'hFFFFFF9C, 32'hFFFFFFF9, 32'hFFFFFFFE, 32'd14, 1'b0, 1'b0, 0);
        @(posedge clk); #1;
        applyStimulus("udiv_5_0", 1'b0, 32'd5, 32'd0, 32'd5, 32'hFFFFFFFF, 1'b0, 1'b0, 0);
        @(posedge clk); #1;
        applyStimulus("sdiv_m5_0", 1'b1, 32'hFFFFFFFB, 32'd0, 32'hFFFFFFFB, 32'hFFFFFFFF, 1'b0, 1'b0, 0);
        @(posedge clk); #1;
        applyStimulus("sdiv_ovf", 1'b1, 32'h80000000, 32'hFFFFFFFF, 32'd0, 32'h80000000, 1'b0, 1'b0, 0);
        @(posedge clk); #1;
        applyStimulus("udiv_min_1", 1'b0, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 32'd0, 1'b0, 1'b0, 0);

        // Second request lands in the IDLE cycle after DONE, one cycle after the operands change.
        @(posedge clk); #1;
        applyStimulus("b2b_first", 1'b0, 32'd100, 32'd7, 32'd2, 32'd14, 1'b1, 1'b0, 0);
        applyStimulus("b2b_second", 1'b0, 32'hFFFFFFFF, 32'h10, 32'hF, 32'h0FFFFFFF, 1'b0, 1'b0, 1);

        @(posedge clk); #1;
        applyStimulus("corrupt", 1'b1, 32'd1000, 32'hFFFFFFFD, 32'd1, 32'hFFFFFEB3, 1'b0, 1'b1, 0);

        // Abort a request with a one-cycle reset ten cycles in; no pulse may follow.
        @(posedge clk); #1;
        bus.in_valid = 1'b1;
        bus.sign     = 1'b0;
        bus.srca     = 32'hDEADBEEF;
        bus.srcb     = 32'h10;
        repeat (10) @(posedge clk);
        #1;
        rst          = 1'b1;
        bus.in_valid = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        checkOutput("abort.out_valid", {31'd0, bus.out_valid}, 32'd0);
        checkOutput("abort.hi", bus.hi, 32'd0);
        checkOutput("abort.lo", bus.lo, 32'd0);
        repeat (40) @(negedge clk);

        @(posedge clk); #1;
        applyStimulus("after_reset", 1'b0, 32'h12345678, 32'h100, 32'h78, 32'h00123456, 1'b0, 1'b0, 0);

        repeat (40) @(negedge clk);
        checkOutput("scoreboard_empty", 32'(sb.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
